// File: rtl/btn_led_ctrl.sv
// Button press classifier (short/long) driving a blinking LED.
// Short press steps blink speed; long press toggles blink enable.
module btn_led_ctrl #(
    parameter int LONG_CYC  = 50_000_000,
    parameter int BASE_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_db,
    output logic       led,
    output logic       led_en,
    output logic [1:0] speed,
    output logic       short_evt,
    output logic       long_evt
);

    localparam int PW = $clog2(LONG_CYC + 1);
    localparam int BW = $clog2(BASE_HALF + 1);
    localparam logic [PW-1:0] LONG = PW'(LONG_CYC);
    localparam logic [BW-1:0] BASE = BW'(BASE_HALF);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] press_cnt, press_nxt;
    logic [BW-1:0] blink_cnt, half;
    logic          btn_prev;
    logic          led_en_nxt, short_nxt, long_nxt;
    logic [1:0]    speed_nxt;
    logic          spd_chg;

    always_comb begin
        state_nxt  = state;
        press_nxt  = press_cnt;
        led_en_nxt = led_en;
        speed_nxt  = speed;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        spd_chg    = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_db && !btn_prev) begin
                    state_nxt = PRESSED;
                    press_nxt = PW'(1);
                end
            end
            PRESSED: begin
                if (!btn_db) begin
                    short_nxt = 1'b1;
                    speed_nxt = speed + 2'd1;
                    spd_chg   = 1'b1;
                    state_nxt = IDLE;
                end else if (press_cnt == LONG) begin
                    long_nxt   = 1'b1;
                    led_en_nxt = !led_en;
                    state_nxt  = HELD;
                end else begin
                    press_nxt = press_cnt + PW'(1);
                end
            end
            HELD: begin
                if (!btn_db) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Half-period follows the speed in force during this cycle.
    assign half = BASE >> speed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            press_cnt <= '0;
            btn_prev  <= 1'b1;
            led_en    <= 1'b1;
            speed     <= 2'd0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            state     <= state_nxt;
            press_cnt <= press_nxt;
            btn_prev  <= btn_db;
            led_en    <= led_en_nxt;
            speed     <= speed_nxt;
            short_evt <= short_nxt;
            long_evt  <= long_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if (!led_en_nxt) begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if (!led_en) begin
            led       <= 1'b1;
            blink_cnt <= '0;
        end else if (spd_chg) begin
            blink_cnt <= '0;
        end else if (blink_cnt == half - BW'(1)) begin
            led       <= !led;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Bench for btn_led_ctrl: vector table, hand sequences, random run
// checked every cycle against a press/blink reference model.
module tb_btn_led_ctrl;

    localparam int LONG = 20;
    localparam int BASE = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_db = 1'b0;
    logic       led, led_en, short_evt, long_evt;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;
    int sc_cnt = 0;
    int lc_cnt = 0;
    bit chk_on = 1'b0;

    btn_led_ctrl #(.LONG_CYC(LONG), .BASE_HALF(BASE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_db(btn_db),
        .led(led),
        .led_en(led_en),
        .speed(speed),
        .short_evt(short_evt),
        .long_evt(long_evt)
    );

    always #5 clk = ~clk;

    // Reference model: presses measured as runs of high samples.
    bit m_prev, m_act, m_fired, m_led, m_en, m_short, m_long;
    int m_run, m_spd, m_el;

    always @(posedge clk) begin
        bit old_en, chg;
        int old_spd, half;
        if (!rst_n) begin
            m_prev = 1; m_act = 0; m_fired = 0; m_run = 0;
            m_led = 0; m_en = 1; m_spd = 0; m_el = 0;
            m_short = 0; m_long = 0;
        end else begin
            m_short = 0; m_long = 0; chg = 0;
            old_en = m_en; old_spd = m_spd;
            if (btn_db) begin
                if (!m_act && !m_prev) begin
                    m_act = 1; m_run = 1; m_fired = 0;
                end else if (m_act && !m_fired) begin
                    m_run++;
                    if (m_run == LONG + 1) begin
                        m_long = 1; m_fired = 1; m_en = !m_en;
                    end
                end
            end else begin
                if (m_act && !m_fired) begin
                    m_short = 1; m_spd = (m_spd + 1) % 4; chg = 1;
                end
                m_act = 0; m_fired = 0;
            end
            m_prev = btn_db;
            half = BASE / (1 << old_spd);
            if (!m_en) begin
                m_led = 0; m_el = 0;
            end else if (!old_en) begin
                m_led = 1; m_el = 0;
            end else if (chg) begin
                m_el = 0;
            end else if (m_el == half - 1) begin
                m_led = !m_led; m_el = 0;
            end else begin
                m_el++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (led !== m_led || led_en !== m_en || speed !== 2'(m_spd) ||
                short_evt !== m_short || long_evt !== m_long) begin
                errors++;
                $display("FAIL model t=%0t got led=%b en=%b spd=%0d s=%b l=%b exp led=%b en=%b spd=%0d s=%b l=%b",
                         $time, led, led_en, speed, short_evt, long_evt,
                         m_led, m_en, m_spd, m_short, m_long);
            end
            checks++;
            if (short_evt === 1'b1 && long_evt === 1'b1) begin
                errors++;
                $display("FAIL excl t=%0t got both events high, expected at most one", $time);
            end
            if (short_evt === 1'b1) sc_cnt++;
            if (long_evt === 1'b1) lc_cnt++;
        end
    end

    task automatic step(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            rst_n = r;
            btn_db = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic r;
        logic b;
        int   n;
        int   en;
        int   spd;
        int   sc;
        int   lc;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2,  1, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 40, 1, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 5,  1, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 3,  1, 1, 1, 0};
        tbl[4]  = '{1'b1, 1'b1, 5,  1, 1, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 3,  1, 2, 2, 0};
        tbl[6]  = '{1'b1, 1'b1, 5,  1, 2, 2, 0};
        tbl[7]  = '{1'b1, 1'b0, 3,  1, 3, 3, 0};
        tbl[8]  = '{1'b1, 1'b1, 5,  1, 3, 3, 0};
        tbl[9]  = '{1'b1, 1'b0, 3,  1, 0, 4, 0};
        tbl[10] = '{1'b1, 1'b1, 30, 0, 0, 4, 1};
        tbl[11] = '{1'b1, 1'b0, 3,  0, 0, 4, 1};
        tbl[12] = '{1'b1, 1'b1, 30, 1, 0, 4, 2};
        tbl[13] = '{1'b1, 1'b0, 3,  1, 0, 4, 2};
        tbl[14] = '{1'b0, 1'b1, 3,  1, 0, 4, 2};
        tbl[15] = '{1'b1, 1'b1, 50, 1, 0, 4, 2};
        tbl[16] = '{1'b1, 1'b0, 2,  1, 0, 4, 2};
        tbl[17] = '{1'b1, 1'b1, 5,  1, 0, 4, 2};
        tbl[18] = '{1'b1, 1'b0, 3,  1, 1, 5, 2};
        tbl[19] = '{1'b1, 1'b1, 10, 1, 1, 5, 2};
        tbl[20] = '{1'b0, 1'b1, 1,  1, 0, 5, 2};
        tbl[21] = '{1'b1, 1'b0, 3,  1, 0, 5, 2};

        @(posedge clk);
        #1;
        for (int k = 0; k < 22; k++) begin
            step(tbl[k].r, tbl[k].b, tbl[k].n);
            chk_on = 1'b1;
            chk($sformatf("vec%0d_en", k), int'(led_en), tbl[k].en);
            chk($sformatf("vec%0d_spd", k), int'(speed), tbl[k].spd);
            chk($sformatf("vec%0d_short", k), sc_cnt, tbl[k].sc);
            chk($sformatf("vec%0d_long", k), lc_cnt, tbl[k].lc);
            if (k == 20) begin
                chk("rst_led", int'(led), 0);
                chk("rst_short", int'(short_evt), 0);
                chk("rst_long", int'(long_evt), 0);
            end
        end

        // Blink phase right after reset at speed 0.
        step(1'b0, 1'b0, 2);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1);
            if (i == 0)  chk("blink_i0", int'(led), 0);
            if (i == 14) chk("blink_i14", int'(led), 0);
            if (i == 15) chk("blink_i15", int'(led), 1);
            if (i == 30) chk("blink_i30", int'(led), 1);
            if (i == 31) chk("blink_i31", int'(led), 0);
        end

        // Long press fires exactly 20 samples after the rise.
        step(1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 2);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 30; i++) begin
                step(1'b1, 1'b1, 1);
                if (i == 19) chk("long_i19", int'(long_evt), 0);
                if (i == 20) begin
                    chk("long_i20", int'(long_evt), 1);
                    chk("long_en", int'(led_en), pass);
                    chk("long_led", int'(led), pass);
                end
                if (i == 21) chk("long_i21", int'(long_evt), 0);
            end
            step(1'b1, 1'b0, 1);
            chk("long_rel_short", int'(short_evt), 0);
            step(1'b1, 1'b0, 2);
        end

        // Short press pulse lands on the cycle after the low sample.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1);
        chk("short_pre", int'(short_evt), 0);
        step(1'b1, 1'b0, 1);
        chk("short_pulse", int'(short_evt), 1);
        chk("short_spd", int'(speed), 1);
        step(1'b1, 1'b0, 1);
        chk("short_once", int'(short_evt), 0);

        // Random presses with occasional resets.
        for (int j = 0; j < 120; j++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 30)
                                              : $urandom_range(1, 8);
            if ($urandom_range(0, 15) == 0)
                step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            step(1'b1, 1'b1, len);
            step(1'b1, 1'b0, $urandom_range(1, 12));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_led_ctrl.md
BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYC, default 50_000_000, the number of consecutive btn_db=1 samples that make a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter BASE_HALF, default 25_000_000, the blink half-period in cycles at speed 0.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port btn_db, input, 1 bit: debounced, positive-logic button level, already synchronous to clk.
REQ-006 SHALL have port led, output, 1 bit: the blinking LED drive.
REQ-007 SHALL have port led_en, output, 1 bit: blink enable state.
REQ-008 SHALL have port speed, output, 2 bits: blink speed index 0..3.
REQ-009 SHALL have port short_evt, output, 1 bit: one-cycle pulse when a short press is accepted.
REQ-010 SHALL have port long_evt, output, 1 bit: one-cycle pulse when a long press is accepted.

Function
REQ-011 SHALL keep btn_prev, the btn_db value from the previous cycle; a press starts only when btn_db=1 and btn_prev=0 (rising edge).
REQ-012 SHALL implement the FSM states IDLE, PRESSED and HELD.
REQ-013 IDLE: on a rising edge, go to PRESSED and set press_cnt=1; otherwise stay in IDLE.
REQ-014 PRESSED with btn_db=1 and press_cnt<LONG_CYC: increment press_cnt.
REQ-015 PRESSED with btn_db=1 and press_cnt==LONG_CYC: assert long_evt for one cycle, toggle led_en and go to HELD, all in the same cycle. The long action fires while the button is still held, not on release.
REQ-016 PRESSED with btn_db=0: assert short_evt for one cycle, set speed=(speed+1) mod 4 (3 wraps to 0) and go to IDLE.
REQ-017 HELD: stay until btn_db=0, then go to IDLE; a release from HELD produces no event.
REQ-018 press_cnt SHALL be wide enough for LONG_CYC and never wraps, because the long action bounds it.
REQ-019 short_evt and long_evt SHALL be registered, mutually exclusive, and never high for more than one consecutive cycle.
REQ-020 Blink half-period SHALL be BASE_HALF>>speed (speed 0..3 gives BASE_HALF, /2, /4, /8); blink_cnt width is sized for BASE_HALF.
REQ-021 With led_en=1: blink_cnt increments each cycle; at blink_cnt==(BASE_HALF>>speed)-1, led toggles and blink_cnt clears.
REQ-022 With led_en=0: led=0 and blink_cnt=0, held continuously.
REQ-023 When led_en transitions 0->1: led<=1 and blink_cnt<=0 in that same cycle.
REQ-024 In the cycle speed changes: blink_cnt<=0 and led keeps its value; the new half-period applies from the next cycle.
REQ-025 If a speed change coincides with a terminal count: the clear takes priority and led does not toggle.
REQ-026 All outputs SHALL be registered; there is no combinational path from btn_db to any output.

Reset
REQ-027 With rst_n=0 at a clk edge: state=IDLE, press_cnt=0, blink_cnt=0, btn_prev=1, led=0, led_en=1, speed=0, short_evt=0, long_evt=0.
REQ-028 Reset asserted mid-press or in HELD SHALL abort the press with no event.
REQ-029 A button held through reset release SHALL be ignored until it is seen low at least once (btn_prev resets to 1).
REQ-030 Reset SHALL have priority over all other behaviour.

Verification (LONG_CYC=20, BASE_HALF=16)
REQ-031 Reset, btn_db=0, run 40 cycles -> led=0 for 16 cycles after reset, then toggles every 16 cycles; led_en=1, speed=0.
REQ-032 btn_db high 5 cycles then low -> one short_evt pulse on the cycle after the falling sample; speed 0->1; half-period becomes 8.
REQ-033 Four short presses -> speed goes 1,2,3,0, with exactly four short_evt pulses.
REQ-034 btn_db high 30 cycles -> long_evt pulses once, 20 samples after the rise; led_en goes 1->0 and led=0; release gives no short_evt. A second 30-cycle hold -> led_en=1 and led=1 immediately.
REQ-035 btn_db held across reset release for 50 cycles -> no events; a later 5-cycle press -> short_evt.
REQ-036 Reset asserted at press_cnt=10 -> no events; all outputs at reset values on the next cycle.
